wide_add_sequencer: RTL and testbench

Multi-cycle controller that performs a (16·WORDS)-bit add or subtract by time-multiplexing a single external 16-bit combinational adder, one word per clock, least-significant word first. It registers both operands on a Start handshake and steps a word index through the adder. Each word's carry-out is carried into the next word through a carry register. The block reports the full-width result, carry and signed overflow with a one-cycle Done pulse. It sits between the operand registers/switch logic and the shared 16-bit adder instance, so the adder is reused for wide arithmetic.

---
 rtl/wide_add_sequencer_if.sv | 39 +++
 rtl/wide_add_sequencer.sv | 156 +++++++++++++++
 tb/tb_wide_add_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wide_add_sequencer_if.sv
// -----------------------------------------------------------------------------
// wide_add_sequencer_if
// Bundles the signals around the wide add/subtract sequencer:
//   request side : Start, Sub, A_in, B_in        (environment -> sequencer)
//   status side  : Busy, Done, Result, Co, Ovf  (sequencer -> environment)
//   adder bus    : Add_A, Add_B, Add_Ci          (sequencer -> shared adder)
//                  Add_S, Add_Co                 (shared adder -> sequencer)
// Modports:
//   master : the sequencer (drives the adder operands and the status)
//   slave  : everything around it (operand logic plus the 16-bit adder)
// -----------------------------------------------------------------------------
interface wide_add_sequencer_if #(
  parameter int WORDS = 4
);
  logic                   Start;
  logic                   Sub;
  logic [16*WORDS-1:0]    A_in;
  logic [16*WORDS-1:0]    B_in;
  logic [15:0]            Add_A;
  logic [15:0]            Add_B;
  logic                   Add_Ci;
  logic [15:0]            Add_S;
  logic                   Add_Co;
  logic                   Busy;
  logic                   Done;
  logic [16*WORDS-1:0]    Result;
  logic                   Co;
  logic                   Ovf;

  modport master (
    input  Start, Sub, A_in, B_in, Add_S, Add_Co,
    output Add_A, Add_B, Add_Ci, Busy, Done, Result, Co, Ovf
  );

  modport slave (
    output Start, Sub, A_in, B_in, Add_S, Add_Co,
    input  Add_A, Add_B, Add_Ci, Busy, Done, Result, Co, Ovf
  );
endinterface

// File: rtl/wide_add_sequencer.sv
// -----------------------------------------------------------------------------
// wide_add_sequencer
// Performs a (16*WORDS)-bit add or subtract by stepping one 16-bit word per
// clock through a shared external combinational adder, least-significant word
// first, rippling the carry through a register between words.
// Ports:
//   Clk    : system clock, rising edge
//   Reset  : synchronous, active-low reset (wins over Start)
//   bus    : wide_add_sequencer_if.master
//            Start/Sub/A_in/B_in request, Busy/Done/Result/Co/Ovf status,
//            Add_A/Add_B/Add_Ci -> adder, Add_S/Add_Co <- adder
// -----------------------------------------------------------------------------
module wide_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  wide_add_sequencer_if.master  bus
);

  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS <= 2) ? 1 : $clog2(WORDS);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_result;
  logic            r_co;
  logic            r_ovf;
  logic            r_busy;
  logic            r_done;
  logic [15:0]     w_add_a;
  logic [15:0]     w_add_b;
  logic            w_add_ci;
  logic            w_last;
  logic            w_ovf;

  // State register
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and adder operand selection
  always_comb begin
    w_next_state = r_state;
    w_add_a      = 16'h0000;
    w_add_b      = 16'h0000;
    w_add_ci     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.Start) begin
          w_next_state = ST_ADD;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_ADD: begin
        w_add_a  = r_a[r_idx*16 +: 16];
        w_add_b  = r_b[r_idx*16 +: 16];
        w_add_ci = r_carry;
        if (w_last) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_ADD;
        end
      end
      ST_DONE: begin
        w_next_state = ST_IDLE;
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign w_last = (r_idx == LAST_IDX);
  // B is already inverted for subtract, so this is the usual same-sign test.
  assign w_ovf  = (w_add_a[15] == w_add_b[15]) && (bus.Add_S[15] != w_add_a[15]);

  // Operand capture, word stepping, result/carry accumulation and status flags
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_co     <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.Start) begin
            r_a      <= bus.A_in;
            // Subtract as A + ~B + 1: the +1 enters through the carry.
            r_b      <= bus.Sub ? ~bus.B_in : bus.B_in;
            r_carry  <= bus.Sub;
            r_idx    <= '0;
            r_result <= '0;
            r_co     <= 1'b0;
            r_ovf    <= 1'b0;
            r_busy   <= 1'b1;
          end else begin
            r_busy   <= 1'b0;
          end
          r_done <= 1'b0;
        end
        ST_ADD: begin
          r_result[r_idx*16 +: 16] <= bus.Add_S;
          r_carry                  <= bus.Add_Co;
          if (w_last) begin
            r_co   <= bus.Add_Co;
            r_ovf  <= w_ovf;
            r_done <= 1'b1;
          end else begin
            r_idx  <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
        default: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Add_A  = w_add_a;
  assign bus.Add_B  = w_add_b;
  assign bus.Add_Ci = w_add_ci;
  assign bus.Busy   = r_busy;
  assign bus.Done   = r_done;
  assign bus.Result = r_result;
  assign bus.Co     = r_co;
  assign bus.Ovf    = r_ovf;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wide_add_sequencer
// Directed bench for wide_add_sequencer (WORDS=4) with a behavioural 16-bit
// adder on the adder bus and a scoreboard of expected wide results.
// -----------------------------------------------------------------------------
module tb_wide_add_sequencer;
  localparam int WORDS = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [65:0] sb_q[$];

  wide_add_sequencer_if #(.WORDS(WORDS)) bus();

  wide_add_sequencer #(.WORDS(WORDS)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // the shared external adder
  assign {bus.Add_Co, bus.Add_S} = {1'b0, bus.Add_A} + {1'b0, bus.Add_B} + {16'd0, bus.Add_Ci};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // {co, ovf, result} of a full-width add/subtract
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b, input logic sub);
    logic [63:0] bn;
    logic [64:0] s;
    logic        ovf;
    bn  = sub ? ~b : b;
    s   = {1'b0, a} + {1'b0, bn} + {64'd0, sub};
    ovf = (a[63] == bn[63]) && (s[63] != a[63]);
    return {s[64], ovf, s[63:0]};
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // scoreboard: compare on every Done pulse
  always @(negedge Clk) begin
    logic [65:0] e;
    if (bus.Done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("done_unexpected", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_result", bus.Result, e[63:0]);
        chk("sb_co", {63'd0, bus.Co}, {63'd0, e[65]});
        chk("sb_ovf", {63'd0, bus.Ovf}, {63'd0, e[64]});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic sub,
                        output int lat, output int busy_cnt, output logic [7:0] ci_bits);
    bus.A_in  = a;
    bus.B_in  = b;
    bus.Sub   = sub;
    bus.Start = 1'b1;
    sb_q.push_back(model(a, b, sub));
    step();
    bus.Start = 1'b0;
    bus.A_in  = {$urandom, $urandom};
    bus.B_in  = {$urandom, $urandom};
    bus.Sub   = 1'($urandom_range(0, 1));
    lat = 0;
    busy_cnt = 0;
    ci_bits = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      if (bus.Busy === 1'b1) busy_cnt++;
      if (k <= 8) ci_bits[k-1] = bus.Add_Ci;
      if (bus.Done === 1'b1) begin
        lat = k;
        break;
      end
      step();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},   {63'd0, bus.Busy},   64'd0);
    chk({tag, "_done"},   {63'd0, bus.Done},   64'd0);
    chk({tag, "_result"}, bus.Result,          64'd0);
    chk({tag, "_co"},     {63'd0, bus.Co},     64'd0);
    chk({tag, "_ovf"},    {63'd0, bus.Ovf},    64'd0);
    chk({tag, "_add_a"},  {48'd0, bus.Add_A},  64'd0);
    chk({tag, "_add_b"},  {48'd0, bus.Add_B},  64'd0);
    chk({tag, "_add_ci"}, {63'd0, bus.Add_Ci}, 64'd0);
  endtask

  initial begin
    int          lat;
    int          bc;
    int          ndone;
    int          t_done[3];
    logic [7:0]  ci;
    logic [65:0] e1;

    // reset with random inputs and Start high
    Reset     = 1'b0;
    bus.Start = 1'b1;
    bus.Sub   = 1'($urandom_range(0, 1));
    bus.A_in  = {$urandom, $urandom};
    bus.B_in  = {$urandom, $urandom};
    step();
    step();
    chk_all_zero("reset");
    bus.Start = 1'b0;
    Reset     = 1'b1;
    step();

    // carry propagation between words
    run_op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, lat, bc, ci);
    chk("carry_latency", 64'(lat), 64'd5);
    chk("carry_busy_cycles", 64'(bc), 64'd5);
    chk("carry_result", bus.Result, 64'h0000_0000_0001_0000);
    chk("carry_co", {63'd0, bus.Co}, 64'd0);
    chk("carry_ovf", {63'd0, bus.Ovf}, 64'd0);
    step();
    chk("carry_busy_after", {63'd0, bus.Busy}, 64'd0);
    chk("carry_done_after", {63'd0, bus.Done}, 64'd0);
    chk("carry_result_hold", bus.Result, 64'h0000_0000_0001_0000);

    // full wrap
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, lat, bc, ci);
    chk("wrap_latency", 64'(lat), 64'd5);
    chk("wrap_result", bus.Result, 64'd0);
    chk("wrap_co", {63'd0, bus.Co}, 64'd1);
    chk("wrap_ovf", {63'd0, bus.Ovf}, 64'd0);
    chk("wrap_ci_words", {60'd0, ci[3:0]}, 64'h0000_0000_0000_000E);
    step();

    // subtract 0 - 1
    run_op(64'h0, 64'h1, 1'b1, lat, bc, ci);
    chk("sub0_latency", 64'(lat), 64'd5);
    chk("sub0_result", bus.Result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("sub0_co", {63'd0, bus.Co}, 64'd0);
    chk("sub0_ovf", {63'd0, bus.Ovf}, 64'd0);
    chk("sub0_ci_word0", {63'd0, ci[0]}, 64'd1);
    step();

    // subtract with signed overflow
    run_op(64'h8000_0000_0000_0000, 64'h1, 1'b1, lat, bc, ci);
    chk("subovf_result", bus.Result, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("subovf_co", {63'd0, bus.Co}, 64'd1);
    chk("subovf_ovf", {63'd0, bus.Ovf}, 64'd1);
    step();

    // random operations, checked by the scoreboard
    for (int r = 0; r < 6; r++) begin
      run_op({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), lat, bc, ci);
      chk("rand_latency", 64'(lat), 64'd5);
      step();
    end

    // Start pulses during ADD and DONE are ignored
    e1 = model(64'h1234_0000_FFFF_8001, 64'h0F0F_F0F0_0001_7FFF, 1'b0);
    sb_q.push_back(e1);
    bus.A_in  = 64'h1234_0000_FFFF_8001;
    bus.B_in  = 64'h0F0F_F0F0_0001_7FFF;
    bus.Sub   = 1'b0;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    step();
    bus.Start = 1'b1;
    bus.Sub   = 1'b1;
    bus.A_in  = 64'hDEAD_BEEF_0000_1111;
    step();
    bus.Start = 1'b0;
    lat = 0;
    for (int k = 3; k <= 20; k++) begin
      if (bus.Done === 1'b1) begin
        lat = k;
        break;
      end
      step();
    end
    chk("hs_latency", 64'(lat), 64'd5);
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    chk("hs_busy_after_done", {63'd0, bus.Busy}, 64'd0);
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.Done === 1'b1) ndone++;
      step();
    end
    chk("hs_no_extra_done", 64'(ndone), 64'd0);
    chk("hs_result_kept", bus.Result, e1[63:0]);

    // Start held high: one operation every WORDS+2 cycles
    bus.A_in = 64'h0001_0002_0003_0004;
    bus.B_in = 64'h0004_0003_0002_0001;
    bus.Sub  = 1'b1;
    for (int k = 0; k < 3; k++) sb_q.push_back(model(64'h0001_0002_0003_0004, 64'h0004_0003_0002_0001, 1'b1));
    bus.Start = 1'b1;
    step();
    ndone = 0;
    for (int t = 1; t <= 40; t++) begin
      if (bus.Done === 1'b1) begin
        t_done[ndone] = t;
        ndone++;
        if (ndone == 3) begin
          bus.Start = 1'b0;
          break;
        end
      end
      step();
    end
    bus.Start = 1'b0;
    chk("held_done_count", 64'(ndone), 64'd3);
    if (ndone == 3) begin
      chk("held_first_done", 64'(t_done[0]), 64'd5);
      chk("held_period_1", 64'(t_done[1] - t_done[0]), 64'd6);
      chk("held_period_2", 64'(t_done[2] - t_done[1]), 64'd6);
    end
    step();
    step();

    // abort with Reset while idx=2
    sb_q.push_back(model(64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 1'b0));
    bus.A_in  = 64'hAAAA_BBBB_CCCC_DDDD;
    bus.B_in  = 64'h1111_2222_3333_4444;
    bus.Sub   = 1'b0;
    bus.Start = 1'b1;
    step();
    bus.Start = 1'b0;
    step();
    step();
    chk("abort_busy_before", {63'd0, bus.Busy}, 64'd1);
    Reset = 1'b0;
    step();
    chk_all_zero("abort");
    sb_q.delete();
    Reset = 1'b1;
    ndone = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.Done === 1'b1) ndone++;
      step();
    end
    chk("abort_no_done", 64'(ndone), 64'd0);
    run_op(64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, lat, bc, ci);
    chk("post_abort_latency", 64'(lat), 64'd5);
    chk("post_abort_result", bus.Result, 64'h1234_5678_9ABC_DF00);
    chk("post_abort_co", {63'd0, bus.Co}, 64'd0);
    step();
    step();
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
